// File: rtl/serial_key_decoder_if.sv
// rtl/serial_key_decoder_if.sv - received byte, timing tick and key handshake bundle
interface serial_key_decoder_if;
  logic [7:0] rx_dat;
  logic       rx_stb;
  logic       tick;
  logic [7:0] key_dat;
  logic       key_rdy;
  logic       key_ack;
  logic       key_ovf;

  modport master (
    output rx_dat, rx_stb, tick, key_ack,
    input  key_dat, key_rdy, key_ovf
  );

  modport slave (
    input  rx_dat, rx_stb, tick, key_ack,
    output key_dat, key_rdy, key_ovf
  );
endinterface

// File: rtl/serial_key_decoder.sv
// rtl/serial_key_decoder.sv - serial byte stream to keystroke decoder with key FIFO
module serial_key_decoder #(
  parameter int         DEPTH       = 4,
  parameter logic [7:0] ESC_TIMEOUT = 8'd40,
  parameter int         CSI_MAX     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_key_decoder_if.slave  bus
);
  localparam int            AW      = $clog2(DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [7:0]    CSI_LIM = 8'(CSI_MAX);

  // SS3 reuses the CSI state; ss3_q tells the two apart
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ESC  = 2'd1,
    S_CSI  = 2'd2
  } state_t;

  state_t         state_q;
  logic           ss3_q;
  logic [7:0]     tmo_q;
  logic [7:0]     len_q;
  logic [7:0]     len_inc;

  logic           push_v;
  logic [7:0]     push_key;
  logic           is_arrow;
  logic [7:0]     arrow_key;

  logic [7:0]     mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [CW-1:0]  cnt_q;
  logic           ovf_q;
  logic           pop;
  logic           push_ok;

  wire [7:0] rx = bus.rx_dat;

  // 'A'..'D' map to 0x80..0x83: low two bits minus one give the arrow index
  assign is_arrow  = (rx >= 8'h41) && (rx <= 8'h44);
  assign arrow_key = {6'b100000, rx[1:0] - 2'd1};
  assign len_inc   = len_q + 8'd1;

  // Key to push this cycle: byte mapping in IDLE, ESC flush, or arrow final
  always_comb begin
    push_v   = 1'b0;
    push_key = 8'h00;
    if (bus.rx_stb) begin
      case (state_q)
        S_IDLE: begin
          if ((rx >= 8'h20) && (rx <= 8'h7E)) begin
            push_v   = 1'b1;
            push_key = rx;
          end else if (rx == 8'h0D) begin
            push_v   = 1'b1;
            push_key = 8'h0D;
          end else if ((rx == 8'h08) || (rx == 8'h7F)) begin
            push_v   = 1'b1;
            push_key = 8'h08;
          end
        end
        S_ESC: begin
          if ((rx != 8'h5B) && (rx != 8'h4F)) begin
            push_v   = 1'b1;
            push_key = 8'h1B;
          end
        end
        S_CSI: begin
          if (is_arrow) begin
            push_v   = 1'b1;
            push_key = arrow_key;
          end
        end
        default: ;
      endcase
    end else if ((state_q == S_ESC) && (tmo_q == 8'd0)) begin
      push_v   = 1'b1;
      push_key = 8'h1B;
    end
  end

  // Escape-sequence parser; a received byte always wins over the tick
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ss3_q   <= 1'b0;
      tmo_q   <= 8'd0;
      len_q   <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.rx_stb && (rx == 8'h1B)) begin
            state_q <= S_ESC;
            tmo_q   <= ESC_TIMEOUT;
          end
        end
        S_ESC: begin
          if (bus.rx_stb) begin
            tmo_q <= 8'd0;
            if (rx == 8'h5B) begin
              state_q <= S_CSI;
              ss3_q   <= 1'b0;
              len_q   <= 8'd0;
            end else if (rx == 8'h4F) begin
              state_q <= S_CSI;
              ss3_q   <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (tmo_q == 8'd0) begin
            state_q <= S_IDLE;
          end else if (bus.tick) begin
            tmo_q <= tmo_q - 8'd1;
          end
        end
        S_CSI: begin
          if (bus.rx_stb) begin
            if (!ss3_q && (rx >= 8'h20) && (rx <= 8'h3F)) begin
              if (len_inc > CSI_LIM) begin
                state_q <= S_IDLE;
                len_q   <= 8'd0;
              end else begin
                len_q <= len_inc;
              end
            end else begin
              state_q <= S_IDLE;
              ss3_q   <= 1'b0;
              len_q   <= 8'd0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop
  assign pop     = bus.key_ack && (cnt_q != '0);
  assign push_ok = push_v && ((cnt_q != FULL) || pop);

  // Key FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_key;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push_ok && !pop) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (!push_ok && pop) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (push_v && !push_ok) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign bus.key_rdy = (cnt_q != '0);
  assign bus.key_dat = (cnt_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.key_ovf = ovf_q;
endmodule
